// File: rtl/wb_pkg.sv
// Shared types and width defaults for the register-file writeback arbiter.
package wb_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 6;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] wa;
    logic [DEF_DATA_W-1:0] wd;
  } wb_req_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ALU  = 2'd1,
    SEL_FIFO = 2'd2
  } wb_sel_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// ALU/load request handshakes plus the register-file write port and status.
interface wb_arbiter_if
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = 4
);

  logic                     alu_valid;
  logic                     alu_ready;
  logic [ADDR_W-1:0]        alu_wa;
  logic [DATA_W-1:0]        alu_wd;
  logic                     mem_valid;
  logic                     mem_ready;
  logic [ADDR_W-1:0]        mem_wa;
  logic [DATA_W-1:0]        mem_wd;
  logic                     we;
  logic [ADDR_W-1:0]        wa;
  logic [DATA_W-1:0]        wd;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     idle;

  modport master (
    output alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd,
    input  alu_ready, mem_ready, we, wa, wd, fifo_count, idle
  );

  modport slave (
    input  alu_valid, alu_wa, alu_wd, mem_valid, mem_wa, mem_wd,
    output alu_ready, mem_ready, we, wa, wd, fifo_count, idle
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering load writebacks; head is valid whenever !empty.
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = wb_pkg::wb_req_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  T               mem [DEPTH];
  logic [PW-1:0]  rptr;
  logic [PW-1:0]  wptr;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= PW'(wptr + 1'b1);
      if (pop_ok)  rptr <= PW'(rptr + 1'b1);
      count <= CW'(count + CW'(push_ok) - CW'(pop_ok));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Single-port register-file write arbiter: ALU first, queued loads otherwise,
// loads forced out when the queue is full. Optional macro: WB_ZERO_REG_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = 4
) (
  input logic          clk,
  input logic          rst,
  wb_arbiter_if.slave  bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
  } req_t;

  req_t    mem_req;
  req_t    head;
  req_t    sel_req;
  wb_sel_t sel;
  logic    full;
  logic    empty;
  logic    push;
  logic    pop;
  logic    issue;

  assign mem_req.wa = bus.mem_wa;
  assign mem_req.wd = bus.mem_wd;

  // Readiness depends only on occupancy so it never waits on this cycle's dequeue.
  assign bus.alu_ready = rst || !full;
  assign bus.mem_ready = rst || !full;
  assign push          = bus.mem_valid && !full;
  assign pop           = (sel == SEL_FIFO);

  wb_fifo #(
    .DEPTH (DEPTH),
    .T     (req_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (mem_req),
    .pop   (pop),
    .head  (head),
    .count (bus.fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    sel        = SEL_NONE;
    sel_req    = head;
    if (full) begin
      sel = SEL_FIFO;
    end else if (bus.alu_valid) begin
      sel        = SEL_ALU;
      sel_req.wa = bus.alu_wa;
      sel_req.wd = bus.alu_wd;
    end else if (!empty) begin
      sel = SEL_FIFO;
    end
  end

`ifdef WB_ZERO_REG_EN
  // Register 0 is hard-wired: accepted requests to it never reach the port.
  assign issue = (sel != SEL_NONE) && (sel_req.wa != '0);
`else
  assign issue = (sel != SEL_NONE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.we <= 1'b0;
      bus.wa <= '0;
      bus.wd <= '0;
    end else begin
      bus.we <= issue;
      if (issue) begin
        bus.wa <= sel_req.wa;
        bus.wd <= sel_req.wd;
      end
    end
  end

  assign bus.idle = (bus.fifo_count == '0) && !bus.we;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: queue-based reference model plus write monitor.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = DEF_DATA_W;
  localparam int unsigned AW    = DEF_ADDR_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) bus ();

  wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int      total = 0;
  int      bad   = 0;
  wb_req_t exp_q[$];
  wb_req_t ld_q[$];
  bit      exp_we;

  bit             a_v, m_v;
  logic [AW-1:0]  a_wa, m_wa;
  logic [DW-1:0]  a_wd, m_wd;
  bit             acc_a, acc_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic bit zero_drop(input logic [AW-1:0] a);
`ifdef WB_ZERO_REG_EN
    return (a == '0);
`else
    return (a != a);
`endif
  endfunction

  // One cycle: check status against the model, drive inputs, advance the model.
  task automatic step(input bit r);
    wb_req_t w;
    bit      have;
    bit      mfull;
    @(negedge clk);
    mfull = (ld_q.size() == DEPTH);
    chk("fifo_count", 64'(bus.fifo_count), 64'(ld_q.size()));
    chk("alu_ready", 64'(bus.alu_ready), 64'(rst || !mfull));
    chk("mem_ready", 64'(bus.mem_ready), 64'(rst || !mfull));
    chk("we", 64'(bus.we), 64'(exp_we));
    chk("idle", 64'(bus.idle), 64'(ld_q.size() == 0 && !exp_we));
    rst           = r;
    bus.alu_valid = a_v;
    bus.alu_wa    = a_wa;
    bus.alu_wd    = a_wd;
    bus.mem_valid = m_v;
    bus.mem_wa    = m_wa;
    bus.mem_wd    = m_wd;
    if (r) begin
      ld_q.delete();
      exp_we = 1'b0;
      acc_a  = 1'b0;
      acc_m  = 1'b0;
    end else begin
      acc_a = a_v && !mfull;
      acc_m = m_v && !mfull;
      have  = 1'b1;
      if (mfull || (!a_v && ld_q.size() > 0)) begin
        w = ld_q.pop_front();
      end else if (a_v) begin
        w.wa = a_wa;
        w.wd = a_wd;
      end else begin
        have = 1'b0;
        w    = '0;
      end
      if (acc_m) begin
        wb_req_t n;
        n.wa = m_wa;
        n.wd = m_wd;
        ld_q.push_back(n);
      end
      exp_we = have && !zero_drop(w.wa);
      if (exp_we) exp_q.push_back(w);
    end
  endtask

  task automatic quiet(input int n);
    a_v = 1'b0;
    m_v = 1'b0;
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  // Write monitor: every registered write must match the scoreboard head.
  initial begin
    wb_req_t w;
    forever begin
      @(posedge clk);
      #1;
      if (bus.we === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got wa=%0h wd=%0h want none", bus.wa, bus.wd);
        end else begin
          w = exp_q.pop_front();
          chk("write_wa", 64'(bus.wa), 64'(w.wa));
          chk("write_wd", 64'(bus.wd), 64'(w.wd));
        end
      end
    end
  end

  initial begin
    int idx;
    exp_we        = 1'b0;
    a_v = 1'b1; a_wa = AW'(9);  a_wd = DW'(32'h1111);
    m_v = 1'b1; m_wa = AW'(12); m_wd = DW'(32'h2222);
    rst           = 1'b1;
    bus.alu_valid = a_v; bus.alu_wa = a_wa; bus.alu_wd = a_wd;
    bus.mem_valid = m_v; bus.mem_wa = m_wa; bus.mem_wd = m_wd;

    // Reset held two cycles with both producers requesting.
    step(1'b1);
    step(1'b1);
    a_v = 1'b0; m_v = 1'b0;
    step(1'b0);
    chk("rst_wa", 64'(bus.wa), 64'd0);
    chk("rst_wd", 64'(bus.wd), 64'd0);
    quiet(2);

    // Single ALU write.
    a_v = 1'b1; a_wa = AW'(5); a_wd = DW'(32'hDEADBEEF);
    step(1'b0);
    quiet(3);

    // ALU beats a simultaneous load.
    a_v = 1'b1; a_wa = AW'(3); a_wd = DW'(1);
    m_v = 1'b1; m_wa = AW'(7); m_wd = DW'(2);
    step(1'b0);
    quiet(4);

    // Fill the FIFO behind a busy ALU, then drain.
    idx = 0;
    a_v = 1'b1; a_wa = AW'(20); a_wd = DW'(32'hA000);
    for (int i = 0; i < 8; i++) begin
      m_v  = (i < 4);
      m_wa = AW'(10 + i);
      m_wd = DW'(32'hB000 + i);
      step(1'b0);
      if (acc_a) begin
        idx++;
        a_wa = AW'(20 + idx);
        a_wd = DW'(32'hA000 + idx);
      end
    end
    quiet(8);

    // Ten back-to-back loads wrap the pointers.
    a_v = 1'b0;
    for (int i = 0; i < 10; i++) begin
      m_v  = 1'b1;
      m_wa = AW'(i);
      m_wd = DW'(i * 32'h11);
      step(1'b0);
    end
    quiet(4);

    // Register 0 request.
    a_v = 1'b1; a_wa = AW'(0); a_wd = DW'(32'h55);
    step(1'b0);
    quiet(3);

    // Reset while the FIFO holds loads.
    a_v = 1'b1; a_wa = AW'(30); a_wd = DW'(32'hC0);
    m_v = 1'b1; m_wa = AW'(31); m_wd = DW'(32'hC1);
    for (int i = 0; i < 4; i++) step(1'b0);
    a_v = 1'b0; m_v = 1'b0;
    step(1'b1);
    quiet(4);

    // Randomized traffic; producers hold requests until accepted.
    a_v = 1'b0; m_v = 1'b0;
    for (int i = 0; i < 500; i++) begin
      bit r;
      if (!a_v || acc_a) begin
        a_v  = ($urandom_range(0, 99) < 50);
        a_wa = AW'($urandom_range(0, 63));
        a_wd = DW'($urandom);
      end
      if (!m_v || acc_m) begin
        m_v  = ($urandom_range(0, 99) < 65);
        m_wa = AW'($urandom_range(0, 63));
        m_wd = DW'($urandom);
      end
      r = ($urandom_range(0, 199) == 0);
      step(r);
      if (r) begin
        acc_a = 1'b1;
        acc_m = 1'b1;
      end
    end
    quiet(12);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-side controller for the CPU register file's single write port. It accepts writeback requests from two producers, the ALU and the memory/load unit, using valid/ready handshakes. It buffers load results in a small FIFO and issues at most one registered write per cycle on the we/wa/wd port. It sits between the execute/memory stages and the register file.

## Interface
- DATA_W, default 32: write data width.
- ADDR_W, default 6: register address width (64 registers).
- DEPTH, default 4: load FIFO entries; power of two, ≥2.

- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- alu_valid, input, 1: ALU writeback request.
- alu_ready, output, 1: ALU request accepted this cycle.
- alu_wa, input, ADDR_W: ALU destination register.
- alu_wd, input, DATA_W: ALU result.
- mem_valid, input, 1: load writeback request.
- mem_ready, output, 1: load FIFO can accept.
- mem_wa, input, ADDR_W: load destination register.
- mem_wd, input, DATA_W: load data.
- we, output, 1: register file write enable (registered).
- wa, output, ADDR_W: register file write address (registered).
- wd, output, DATA_W: register file write data (registered).
- fifo_count, output, $clog2(DEPTH)+1: current load FIFO occupancy.
- idle, output, 1: fifo_count==0 and we==0.

## Operation
- Handshake: a transfer occurs on a source in any cycle where valid && ready. Producers hold valid, wa and wd stable until that cycle.
- mem_ready = (fifo_count < DEPTH). This is combinational from the count only, not from the dequeue. A mem transfer enqueues {mem_wa, mem_wd} at the tail.
- Arbitration is evaluated every cycle in priority order:
  - FIFO full (count==DEPTH): issue the FIFO head; alu_ready=0.
  - Else if alu_valid: issue the ALU request; alu_ready=1.
  - Else if FIFO non-empty: issue the FIFO head.
  - Else: no issue.
- alu_ready is 0 only in the FIFO-full case.
- Issue: on the next clk edge, we<=1, wa<=selected address, wd<=selected data. With no issue, we<=0 and wa/wd hold their previous values.
- A simultaneous enqueue and dequeue leaves count unchanged. An enqueue into an empty FIFO cannot be issued in the same cycle.
- Ordering: ALU writes may overtake queued loads. Producers guarantee no outstanding same-address writes across the two sources; the block does not check this.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values: we=0, wa=0, wd=0, fifo_count=0, idle=1, head/tail pointers=0. mem_ready=1 and alu_ready=1 during and after reset.
- A reset asserted mid-operation discards all FIFO contents and any pending write. A write registered in the same cycle as rst is suppressed.
- ALU latency: accepted at cycle N → we=1 at N+1.
- Load latency: enqueued at N → earliest we=1 at N+2.
- Throughput: one write per cycle, sustained.
- Full FIFO with alu_valid held high: ALU stalls exactly until count drops below DEPTH. Each full cycle issues one load.

## Configuration
- WB_ZERO_REG_EN:
  - Defined: requests with address 0 still complete their handshake and dequeue normally. They never assert we, and wa/wd hold their previous values. This gives register 0 hard-zero semantics.
  - Undefined: address 0 is written like any other register.

## Structure
- Package wb_pkg:
  - DATA_W and ADDR_W defaults.
  - typedef struct packed wb_req_t {logic [ADDR_W-1:0] wa; logic [DATA_W-1:0] wd;}.
  - enum wb_sel_t {SEL_NONE, SEL_ALU, SEL_FIFO}.
- Sub-module wb_fifo:
  - Synchronous FIFO of wb_req_t, DEPTH entries.
  - Ports: push, pop, head, count, full, empty.
  - Reset clears the pointers and count.
- wb_arbiter holds the selection logic and the output register.

## Test plan
- Reset: hold rst 2 cycles with both valids high → we=0, wa=0, wd=0, fifo_count=0, idle=1, no FIFO entry retained.
- Single ALU write: alu_valid=1, alu_wa=5, alu_wd=0xDEADBEEF for one cycle → next cycle we=1, wa=5, wd=0xDEADBEEF; following cycle we=0.
- ALU priority: alu (wa=3, wd=1) and mem (wa=7, wd=2) valid in the same cycle → write to 3 at N+1, write to 7 at N+2, fifo_count returns to 0.
- FIFO full: alu_valid held high for 8 cycles while pushing 4 loads (wa=10..13) → after 4 ALU writes, fifo_count=4, alu_ready=0, mem_ready=0. Then loads 10..13 issue in order and alu_ready returns to 1 once count<4.
- Wrap-around: 10 back-to-back loads (wa=i, wd=i*0x11) with ALU idle → 10 consecutive writes in order, no drops, no duplicates.
- Zero register with WB_ZERO_REG_EN defined: alu_wa=0, alu_wd=0x55 → alu_ready=1, we stays 0. Without the macro → we=1, wa=0, wd=0x55.
